// File: rtl/uart_tx_fifo_if.sv
// Transmit-side handshake bundle for uart_tx_fifo: write port, FIFO flags,
// frame status and the serial line.
interface uart_tx_fifo_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    i_wr_en;
   logic [PAYLOAD_BITS-1:0] i_data;
   logic                    o_full;
   logic                    o_empty;
   logic                    o_overflow;
   logic                    o_tx_busy;
   logic                    o_tx_done;
   logic                    o_serial_data;

   modport master (
      output i_wr_en, i_data,
      input  o_full, o_empty, o_overflow, o_tx_busy, o_tx_done, o_serial_data
   );

   modport slave (
      input  i_wr_en, i_data,
      output o_full, o_empty, o_overflow, o_tx_busy, o_tx_done, o_serial_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames are sent back to back while
// data is queued, with optional parity and one or two stop bits.
module uart_tx_fifo #(
   parameter int BIT_RATE     = 115200,
   parameter int CLK_FREQ     = 10_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_fifo_if.slave  bus
);
   localparam int CPB   = CLK_FREQ / BIT_RATE;
   localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BIT_W = $clog2(PAYLOAD_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]          count_q;
   logic                    overflow_q;
   logic                    full, empty, push, pop;

   assign full  = (count_q == FIFO_FULL);
   assign empty = (count_q == '0);
   assign push  = bus.i_wr_en & ~full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
         overflow_q <= bus.i_wr_en & full;
      end
   end

   // NOTE: storage has no reset; the occupancy count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.i_data;
   end

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIT_W-1:0]        idx_q, idx_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic                    parity_q, parity_d;
   logic                    serial_q, serial_d;
   logic                    bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         serial_q <= serial_d;
      end
   end

   // NOTE: every next-state signal is defaulted first so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      serial_d = serial_q;
      pop      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d    = '0;
            serial_d = 1'b1;
            pop      = ~empty;
         end
         S_START: if (bit_end) begin
            state_d  = S_DATA;
            cnt_d    = '0;
            idx_d    = '0;
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
         end
         S_DATA: if (bit_end) begin
            cnt_d = '0;
            if (idx_q == DATA_LAST) begin
               idx_d = '0;
               if (PARITY != 0) begin
                  state_d  = S_PARITY;
                  serial_d = parity_q;
               end else begin
                  state_d  = S_STOP;
                  serial_d = 1'b1;
               end
            end else begin
               idx_d    = idx_q + BIT_W'(1);
               serial_d = shift_q[0];
               shift_d  = shift_q >> 1;
            end
         end
         S_PARITY: if (bit_end) begin
            state_d  = S_STOP;
            cnt_d    = '0;
            idx_d    = '0;
            serial_d = 1'b1;
         end
         S_STOP: if (bit_end) begin
            cnt_d = '0;
            if (idx_q == STOP_LAST) begin
               state_d  = S_IDLE;
               serial_d = 1'b1;
               pop      = ~empty;
            end else begin
               idx_d = idx_q + BIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Popping always begins a new frame with the start bit on the next cycle.
      if (pop) begin
         state_d  = S_START;
         cnt_d    = '0;
         serial_d = 1'b0;
         shift_d  = mem_q[rd_ptr_q];
         parity_d = (^mem_q[rd_ptr_q]) ^ (PARITY == 2);
      end
   end

   assign bus.o_full        = full;
   assign bus.o_empty       = empty;
   assign bus.o_overflow    = overflow_q;
   assign bus.o_tx_busy     = (state_q != S_IDLE);
   assign bus.o_tx_done     = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
   assign bus.o_serial_data = serial_q;
endmodule
